// File: rtl/obs_pkg.sv
// Shared tags, FSM state type and width helpers for the OBS overlap-collect stage.
package obs_pkg;

   localparam logic [1:0] TAG_P1 = 2'd0;
   localparam logic [1:0] TAG_P2 = 2'd1;
   localparam logic [1:0] TAG_P3 = 2'd2;
   localparam logic [1:0] TAG_P4 = 2'd3;

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_t;

   function automatic int sub_w(input int n);
      return n - 1;
   endfunction

   function automatic int res_w(input int n);
      return 2 * n - 1;
   endfunction

endpackage

// File: rtl/obs_overlap_xor.sv
// Combinational GF(2) four-way overlap: interleaves P1 / (P2^P3) / P4 into the 2N-1 bit product.
module obs_overlap_xor
   import obs_pkg::*;
#(
   parameter int N = 24
) (
   input  logic [sub_w(N)-1:0] p1,
   input  logic [sub_w(N)-1:0] p2,
   input  logic [sub_w(N)-1:0] p3,
   input  logic [sub_w(N)-1:0] p4,
   output logic [res_w(N)-1:0] res
);

   // Even result bits: P1 contributes up to i = N-2, P4 (shifted by one slot) from i = 1.
   for (genvar gi = 0; gi < N; gi++) begin : g_even
      if (gi == 0) begin : g_lo
         assign res[0] = p1[0];
      end else if (gi == N - 1) begin : g_hi
         assign res[2*gi] = p4[gi-1];
      end else begin : g_mid
         assign res[2*gi] = p1[gi] ^ p4[gi-1];
      end
   end

   for (genvar gi = 0; gi < N - 1; gi++) begin : g_odd
      assign res[2*gi+1] = p2[gi] ^ p3[gi];
   end

endmodule

// File: rtl/obs_overlap_collect.sv
// Collects the four tagged sub-products in any order, then emits the registered overlapped product.
module obs_overlap_collect
   import obs_pkg::*;
#(
   parameter int N             = 24,
   parameter bit DUP_OVERWRITE = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_tag,
   input  logic [sub_w(N)-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [res_w(N)-1:0] out_data,
   output logic                err_dup
);

   localparam int SW = sub_w(N);
   localparam int RW = res_w(N);

   state_t            state_reg, state_next;
   logic [3:0]        bitmap_reg, bitmap_next;
   logic [RW-1:0]     out_data_reg, out_data_next;
   logic              err_dup_reg, err_dup_next;

   logic [3:0][SW-1:0] operand;
   logic [3:0]         tag_onehot;
   logic [3:0]         bitmap_set;
   logic               accept;
   logic               tag_seen;
   logic [RW-1:0]      xor_res;

   assign in_ready   = (state_reg == COLLECT);
   assign out_valid  = (state_reg == EMIT);
   assign out_data   = out_data_reg;
   assign err_dup    = err_dup_reg;

   assign accept     = in_valid && in_ready;
   assign tag_onehot = 4'b0001 << in_tag;
   assign tag_seen   = |(bitmap_reg & tag_onehot);
   assign bitmap_set = bitmap_reg | tag_onehot;

   // The completing beat bypasses its slot so the result is ready on the same edge.
   for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      logic [SW-1:0] slot_reg;
      logic          hit;

      assign hit          = accept && (in_tag == 2'(gi));
      assign operand[gi]  = hit ? in_data : slot_reg;

      always_ff @(posedge clk) begin
         if (!rst && !clr && hit && (!tag_seen || DUP_OVERWRITE)) begin
            slot_reg <= in_data;
         end
      end
   end

   obs_overlap_xor #(
      .N (N)
   ) u_xor (
      .p1  (operand[TAG_P1]),
      .p2  (operand[TAG_P2]),
      .p3  (operand[TAG_P3]),
      .p4  (operand[TAG_P4]),
      .res (xor_res)
   );

   always_comb begin
      state_next    = state_reg;
      bitmap_next   = bitmap_reg;
      out_data_next = out_data_reg;
      err_dup_next  = 1'b0;
      case (state_reg)
         COLLECT: begin
            if (accept) begin
               if (tag_seen) begin
                  err_dup_next = 1'b1;
               end else if (bitmap_set == 4'hF) begin
                  bitmap_next   = 4'h0;
                  out_data_next = xor_res;
                  state_next    = EMIT;
               end else begin
                  bitmap_next = bitmap_set;
               end
            end
         end
         EMIT: begin
            if (out_ready) begin
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_reg    <= COLLECT;
         bitmap_reg   <= 4'h0;
         out_data_reg <= '0;
         err_dup_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bitmap_reg   <= bitmap_next;
         out_data_reg <= out_data_next;
         err_dup_reg  <= err_dup_next;
      end
   end

endmodule

// File: tb/tb_obs_overlap_collect.sv
// Directed bench: three instances (N=4 overwrite, N=4 drop, N=24) driven in lockstep, scoreboard per instance.
module tb_obs_overlap_collect;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clr, in_valid, out_ready;
   logic [1:0]  in_tag;
   logic [2:0]  in_data4;
   logic [22:0] in_data24;

   logic        in_ready_a, in_ready_b, in_ready_c;
   logic        out_valid_a, out_valid_b, out_valid_c;
   logic [6:0]  out_data_a, out_data_b;
   logic [46:0] out_data_c;
   logic        err_dup_a, err_dup_b, err_dup_c;

   int checks = 0;
   int errors = 0;
   int dup_cnt_a = 0, dup_cnt_b = 0, dup_cnt_c = 0;
   int txn = 0;

   logic [46:0] q_a[$], q_b[$], q_c[$];

   obs_overlap_collect #(.N(4), .DUP_OVERWRITE(1'b1)) dut_a (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_tag(in_tag), .in_data(in_data4), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .err_dup(err_dup_a));

   obs_overlap_collect #(.N(4), .DUP_OVERWRITE(1'b0)) dut_b (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_tag(in_tag), .in_data(in_data4), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .err_dup(err_dup_b));

   obs_overlap_collect #(.N(24), .DUP_OVERWRITE(1'b1)) dut_c (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_c),
      .in_tag(in_tag), .in_data(in_data24), .out_valid(out_valid_c), .out_ready(out_ready),
      .out_data(out_data_c), .err_dup(err_dup_c));

   always @(posedge clk) begin
      if (err_dup_a) dup_cnt_a <= dup_cnt_a + 1;
      if (err_dup_b) dup_cnt_b <= dup_cnt_b + 1;
      if (err_dup_c) dup_cnt_c <= dup_cnt_c + 1;
   end

   function automatic logic [46:0] spread(input logic [22:0] x, input int n);
      logic [46:0] r;
      r = '0;
      for (int i = 0; i < n - 1; i++) r[2*i] = x[i];
      return r;
   endfunction

   function automatic logic [46:0] model(input int n, input logic [22:0] p1, input logic [22:0] p2,
                                         input logic [22:0] p3, input logic [22:0] p4);
      return spread(p1, n) ^ (spread(p2 ^ p3, n) << 1) ^ (spread(p4, n) << 2);
   endfunction

   task automatic chk(input string tag, input logic [46:0] obs, input logic [46:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] tag, input logic [2:0] d4, input logic [22:0] d24);
      in_valid  = 1'b1;
      in_tag    = tag;
      in_data4  = d4;
      in_data24 = d24;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic collect(input string name);
      int n;
      logic [46:0] ea, eb, ec;
      n = 0;
      while (!out_valid_a && n < 20) begin
         tick();
         n++;
      end
      chk({name, "_valid_a"}, 47'(out_valid_a), 47'd1);
      chk({name, "_valid_c"}, 47'(out_valid_c), 47'd1);
      if (q_a.size() == 0 || q_b.size() == 0 || q_c.size() == 0) begin
         chk({name, "_sb_empty"}, 47'd1, 47'd0);
      end else begin
         ea = q_a.pop_front();
         eb = q_b.pop_front();
         ec = q_c.pop_front();
         chk({name, "_data_a"}, 47'(out_data_a), ea);
         chk({name, "_data_b"}, 47'(out_data_b), eb);
         chk({name, "_data_c"}, out_data_c, ec);
      end
      txn++;
      $display("txn %0d %s: a=%h b=%h c=%h", txn, name, out_data_a, out_data_b, out_data_c);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({name, "_drop_valid"}, 47'(out_valid_a), 47'd0);
      chk({name, "_ready_back"}, 47'({in_ready_a, in_ready_b, in_ready_c}), 47'h7);
   endtask

   logic [22:0] v1, v2, v3, v4, w2;
   int d0;

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_tag = 2'd0; in_data4 = '0; in_data24 = '0;
      tick(); tick(); tick();
      rst = 1'b0;
      chk("rst_in_ready", 47'({in_ready_a, in_ready_b, in_ready_c}), 47'h7);
      chk("rst_out_valid", 47'({out_valid_a, out_valid_b, out_valid_c}), 47'h0);
      chk("rst_out_data_a", 47'(out_data_a), 47'h0);
      chk("rst_out_data_c", out_data_c, 47'h0);
      chk("rst_err_dup", 47'({err_dup_a, err_dup_b, err_dup_c}), 47'h0);

      // In-order beats, in_valid held high.
      v1 = 23'($urandom); v2 = 23'($urandom); v3 = 23'($urandom); v4 = 23'($urandom);
      q_a.push_back(47'h49); q_b.push_back(47'h49); q_c.push_back(model(24, v1, v2, v3, v4));
      send(2'd0, 3'b101, v1);
      chk("lat_not_early", 47'(out_valid_a), 47'd0);
      send(2'd1, 3'b011, v2);
      send(2'd2, 3'b001, v3);
      chk("lat_not_early3", 47'(out_valid_a), 47'd0);
      send(2'd3, 3'b110, v4);
      chk("lat_valid", 47'({out_valid_a, out_valid_b, out_valid_c}), 47'h7);
      chk("emit_in_ready", 47'({in_ready_a, in_ready_b, in_ready_c}), 47'h0);
      collect("inorder");

      // Out-of-order with gaps, no duplicate expected.
      d0 = dup_cnt_a + dup_cnt_b + dup_cnt_c;
      v1 = 23'($urandom); v2 = 23'($urandom); v3 = 23'($urandom); v4 = 23'($urandom);
      q_a.push_back(47'h49); q_b.push_back(47'h49); q_c.push_back(model(24, v1, v2, v3, v4));
      send(2'd3, 3'b110, v4); tick();
      send(2'd1, 3'b011, v2); tick(); tick();
      send(2'd0, 3'b101, v1); tick();
      send(2'd2, 3'b001, v3);
      collect("shuffled");
      chk("shuffled_no_dup", 47'(dup_cnt_a + dup_cnt_b + dup_cnt_c - d0), 47'd0);

      // N=24 corner: all-ones P1/P4, P2 = P3.
      v2 = 23'($urandom);
      q_a.push_back(model(4, 23'd7, 23'd2, 23'd2, 23'd7));
      q_b.push_back(model(4, 23'd7, 23'd2, 23'd2, 23'd7));
      q_c.push_back((47'd1 << 46) | 47'd1);
      send(2'd0, 3'b111, 23'h7FFFFF);
      send(2'd1, 3'b010, v2);
      send(2'd2, 3'b010, v2);
      send(2'd3, 3'b111, 23'h7FFFFF);
      collect("n24_corner");

      // Duplicate tag 1: overwrite vs drop.
      d0 = dup_cnt_a;
      v1 = 23'($urandom); v2 = 23'($urandom); w2 = 23'($urandom); v3 = 23'($urandom); v4 = 23'($urandom);
      q_a.push_back(model(4, 23'd5, 23'd7, 23'd1, 23'd6));
      q_b.push_back(47'h49);
      q_c.push_back(model(24, v1, w2, v3, v4));
      send(2'd1, 3'b011, v2);
      send(2'd1, 3'b111, w2);
      chk("dup_pulse", 47'({err_dup_a, err_dup_b, err_dup_c}), 47'h7);
      send(2'd0, 3'b101, v1);
      chk("dup_one_cycle", 47'({err_dup_a, err_dup_b, err_dup_c}), 47'h0);
      send(2'd2, 3'b001, v3);
      send(2'd3, 3'b110, v4);
      collect("dup");
      chk("dup_count", 47'(dup_cnt_a - d0), 47'd1);

      // Backpressure with a beat offered during EMIT.
      v1 = 23'($urandom); v2 = 23'($urandom); v3 = 23'($urandom); v4 = 23'($urandom);
      q_a.push_back(47'h49); q_b.push_back(47'h49); q_c.push_back(model(24, v1, v2, v3, v4));
      send(2'd2, 3'b001, v3);
      send(2'd0, 3'b101, v1);
      send(2'd3, 3'b110, v4);
      send(2'd1, 3'b011, v2);
      in_valid = 1'b1; in_tag = 2'd0; in_data4 = 3'b111; in_data24 = 23'h7FFFFF;
      for (int i = 0; i < 10; i++) begin
         chk("bp_stable_a", 47'(out_data_a), 47'h49);
         chk("bp_in_ready", 47'({in_ready_a, in_ready_c}), 47'h0);
         tick();
      end
      in_valid = 1'b0;
      collect("backpressure");

      // Abort after two beats, with a beat offered in the clr cycle.
      d0 = dup_cnt_a + dup_cnt_c;
      send(2'd0, 3'b111, 23'h7FFFFF);
      send(2'd1, 3'b111, 23'h7FFFFF);
      clr = 1'b1; in_valid = 1'b1; in_tag = 2'd2; in_data4 = 3'b111; in_data24 = 23'h7FFFFF;
      tick();
      clr = 1'b0; in_valid = 1'b0;
      chk("clr_state", 47'({in_ready_a, out_valid_a, err_dup_a}), 47'h4);
      v1 = 23'($urandom); v2 = 23'($urandom); v3 = 23'($urandom); v4 = 23'($urandom);
      q_a.push_back(47'h49); q_b.push_back(47'h49); q_c.push_back(model(24, v1, v2, v3, v4));
      send(2'd2, 3'b001, v3);
      send(2'd3, 3'b110, v4);
      chk("clr_no_early", 47'(out_valid_a), 47'd0);
      send(2'd0, 3'b101, v1);
      chk("clr_no_early2", 47'(out_valid_a), 47'd0);
      send(2'd1, 3'b011, v2);
      collect("after_clr");
      chk("clr_no_dup", 47'(dup_cnt_a + dup_cnt_c - d0), 47'd0);

      // rst while in EMIT drops the pending result.
      send(2'd0, 3'b101, 23'h1); send(2'd1, 3'b011, 23'h2);
      send(2'd2, 3'b001, 23'h4); send(2'd3, 3'b110, 23'h8);
      chk("pre_rst_valid", 47'(out_valid_a), 47'd1);
      rst = 1'b1; tick(); rst = 0;
      chk("rst_emit_valid", 47'({out_valid_a, out_valid_b, out_valid_c}), 47'h0);
      chk("rst_emit_data_a", 47'(out_data_a), 47'h0);
      chk("rst_emit_data_c", out_data_c, 47'h0);
      chk("rst_emit_ready", 47'({in_ready_a, in_ready_b, in_ready_c}), 47'h7);

      // clr while in EMIT behaves the same way.
      send(2'd0, 3'b101, 23'h1); send(2'd1, 3'b011, 23'h2);
      send(2'd2, 3'b001, 23'h4); send(2'd3, 3'b110, 23'h8);
      chk("pre_clr_valid", 47'(out_valid_c), 47'd1);
      clr = 1'b1; tick(); clr = 0;
      chk("clr_emit_valid", 47'({out_valid_a, out_valid_c}), 47'h0);
      chk("clr_emit_data_a", 47'(out_data_a), 47'h0);
      chk("clr_emit_ready", 47'({in_ready_a, in_ready_c}), 47'h3);

      // One final normal result after the aborts.
      v1 = 23'($urandom); v2 = 23'($urandom); v3 = 23'($urandom); v4 = 23'($urandom);
      q_a.push_back(model(4, 23'd3, 23'd5, 23'd6, 23'd4));
      q_b.push_back(model(4, 23'd3, 23'd5, 23'd6, 23'd4));
      q_c.push_back(model(24, v1, v2, v3, v4));
      send(2'd1, 3'b101, v2); send(2'd3, 3'b100, v4);
      send(2'd0, 3'b011, v1); send(2'd2, 3'b110, v3);
      collect("final");
      chk("sb_drained", 47'(q_a.size() + q_b.size() + q_c.size()), 47'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
